// File: rtl/aes_block_serializer.sv
// Frames one 128-bit AES result block as a byte stream: a header byte, then 16 data bytes.
// Define AES_SER_CHECKSUM_EN to append an XOR checksum byte to each frame.
module aes_block_serializer #(
  parameter bit         MSB_FIRST = 1'b1,
  parameter logic [3:0] HDR_SYNC  = 4'hA
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [127:0] blk_data,
  input  logic [1:0]   blk_tag,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic [7:0]   tx_data,
  output logic         tx_last,
  output logic         busy,
  output logic [15:0]  blk_count
);

  localparam int unsigned BLK_W  = 128;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned TAG_W  = 2;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(15);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_CSUM} state_t;

  state_t             state, state_nxt;
  logic [BLK_W-1:0]   shreg;
  logic [TAG_W-1:0]   tag;
  logic [IDX_W-1:0]   idx;
  logic [BYTE_W-1:0]  cur_byte;
  logic               accept;
  logic               data_fire;
  logic               frame_done;

`ifdef AES_SER_CHECKSUM_EN
  logic [BYTE_W-1:0]  csum;
`endif

  assign cur_byte  = MSB_FIRST ? shreg[BLK_W-1 -: BYTE_W] : shreg[BYTE_W-1:0];
  assign accept    = blk_valid && blk_ready;
  assign data_fire = (state == S_DATA) && tx_ready;
`ifdef AES_SER_CHECKSUM_EN
  assign frame_done = (state == S_CSUM) && tx_ready;
`else
  assign frame_done = data_fire && (idx == IDX_LAST);
`endif

  // State register; reset drops tx_valid immediately and discards any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept)   state_nxt = S_HDR;
      S_HDR:  if (tx_ready) state_nxt = S_DATA;
      S_DATA: begin
        if (tx_ready && (idx == IDX_LAST)) begin
`ifdef AES_SER_CHECKSUM_EN
          state_nxt = S_CSUM;
`else
          state_nxt = S_IDLE;
`endif
        end
      end
`ifdef AES_SER_CHECKSUM_EN
      S_CSUM: if (tx_ready) state_nxt = S_IDLE;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from registered state and datapath only, so they hold while stalled.
  always_comb begin
    blk_ready = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = '0;
    tx_last   = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE: begin
        blk_ready = en;
        busy      = 1'b0;
      end
      S_HDR: begin
        tx_valid = 1'b1;
        tx_data  = {HDR_SYNC, 2'b00, tag};
      end
      S_DATA: begin
        tx_valid = 1'b1;
        tx_data  = cur_byte;
`ifndef AES_SER_CHECKSUM_EN
        tx_last  = (idx == IDX_LAST);
`endif
      end
`ifdef AES_SER_CHECKSUM_EN
      S_CSUM: begin
        tx_valid = 1'b1;
        tx_data  = csum;
        tx_last  = 1'b1;
      end
`endif
      default: busy = 1'b0;
    endcase
  end

  // Block shift register, tag, byte index and frame counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg     <= '0;
      tag       <= '0;
      idx       <= '0;
      blk_count <= '0;
    end else begin
      if (accept) begin
        shreg <= blk_data;
        tag   <= blk_tag;
        idx   <= '0;
      end else if (data_fire) begin
        shreg <= MSB_FIRST ? {shreg[BLK_W-BYTE_W-1:0], BYTE_W'(0)}
                           : {BYTE_W'(0), shreg[BLK_W-1:BYTE_W]};
        if (idx != IDX_LAST) idx <= idx + IDX_W'(1);
      end
      if (frame_done) blk_count <= blk_count + CNT_W'(1);
    end
  end

`ifdef AES_SER_CHECKSUM_EN
  // Running XOR of the data bytes as they leave; header is excluded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         csum <= '0;
    else if (accept)    csum <= '0;
    else if (data_fire) csum <= csum ^ cur_byte;
  end
`endif

endmodule

// File: tb/tb_aes_block_serializer.sv
// Directed bench for aes_block_serializer: MSB-first and LSB-first framing, stalls, enable, reset.
module tb_aes_block_serializer;

`ifdef AES_SER_CHECKSUM_EN
  localparam int NB = 18;
`else
  localparam int NB = 17;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b1;
  logic         blk_valid = 1'b0;
  logic         blk_ready;
  logic [127:0] blk_data = '0;
  logic [1:0]   blk_tag = '0;
  logic         tx_valid;
  logic         tx_ready = 1'b1;
  logic [7:0]   tx_data;
  logic         tx_last;
  logic         busy;
  logic [15:0]  blk_count;

  logic         b_valid = 1'b0;
  logic         b_ready;
  logic [127:0] b_data = '0;
  logic [1:0]   b_tag = '0;
  logic         b_tx_valid;
  logic [7:0]   b_tx_data;
  logic         b_tx_last;
  logic         b_busy;
  logic [15:0]  b_count;

  int passed = 0;
  int total  = 0;
  int failed = 0;
  logic [7:0] exp_b [0:17];

  aes_block_serializer #(.MSB_FIRST(1'b1), .HDR_SYNC(4'hA)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_data(blk_data), .blk_tag(blk_tag), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_last(tx_last), .busy(busy), .blk_count(blk_count)
  );

  aes_block_serializer #(.MSB_FIRST(1'b0), .HDR_SYNC(4'hA)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .blk_valid(b_valid), .blk_ready(b_ready),
    .blk_data(b_data), .blk_tag(b_tag), .tx_valid(b_tx_valid), .tx_ready(1'b1),
    .tx_data(b_tx_data), .tx_last(b_tx_last), .busy(b_busy), .blk_count(b_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected frame from the bench's own byte ordering and XOR model
  function automatic void fill(input logic [127:0] d, input logic [1:0] t, input bit msb);
    logic [7:0] c;
    c = 8'h00;
    exp_b[0] = {4'hA, 2'b00, t};
    for (int k = 0; k < 16; k++) begin
      exp_b[k+1] = msb ? d[127-8*k -: 8] : d[8*k +: 8];
      c = c ^ exp_b[k+1];
    end
    exp_b[17] = c;
  endfunction

  task automatic send_block(input logic [127:0] d, input logic [1:0] t);
    int cyc;
    blk_data  = d;
    blk_tag   = t;
    blk_valid = 1'b1;
    cyc = 0;
    while (!blk_ready && cyc < 50) begin
      tick();
      cyc++;
    end
    chk("accept_ready", 32'(blk_ready), 32'd1);
    tick();
    blk_valid = 1'b0;
    blk_data  = '1;
    blk_tag   = 2'd2;
    chk("hdr_latency", 32'(tx_valid), 32'd1);
  endtask

  task automatic recv_frame(input int n, input bit rnd, input int en_off, input int stop);
    int i;
    int cyc;
    bit stalled;
    logic [7:0] pd;
    i = 0; cyc = 0; stalled = 1'b0; pd = 8'h00;
    while (i < n && cyc < 500) begin
      if (i == stop) break;
      if (i == en_off) en = 1'b0;
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stalled) chk("hold_data", 32'(tx_data), 32'(pd));
      if (tx_valid && tx_ready) begin
        chk("byte", 32'(tx_data), 32'(exp_b[i]));
        chk("last", 32'(tx_last), 32'(i == n - 1));
        i++;
        stalled = 1'b0;
      end else begin
        stalled = tx_valid;
        pd = tx_data;
      end
      tick();
      cyc++;
    end
    if (stop < 0) chk("frame_done", 32'(i), 32'(n));
    tx_ready = 1'b1;
  endtask

  initial begin
    logic [143:0] v;
    // Reset state
    #12;
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(blk_count), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_ready", 32'(blk_ready), 32'd1);

    // Known-answer frame, hand-computed bytes and checksum
    v = 144'hA1_69c4e0d86a7b0430d8cdb78070b4c55a_C9;
    for (int k = 0; k < 18; k++) exp_b[k] = v[143-8*k -: 8];
    send_block(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 2'd1);
    recv_frame(NB, 1'b0, -1, -1);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_count", 32'(blk_count), 32'd1);

    // Random backpressure, same frame
    send_block(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 2'd1);
    recv_frame(NB, 1'b1, -1, -1);
    chk("t3_count", 32'(blk_count), 32'd2);

    // LSB-first instance
    b_data  = 128'h000102030405060708090a0b0c0d0e0f;
    b_tag   = 2'd3;
    b_valid = 1'b1;
    chk("lsb_ready", 32'(b_ready), 32'd1);
    tick();
    b_valid = 1'b0;
    fill(128'h000102030405060708090a0b0c0d0e0f, 2'd3, 1'b0);
    chk("lsb_hdr", 32'(b_tx_data), 32'hA3);
    for (int k = 0; k < NB; k++) begin
      chk("lsb_valid", 32'(b_tx_valid), 32'd1);
      chk("lsb_byte", 32'(b_tx_data), 32'(exp_b[k]));
      chk("lsb_last", 32'(b_tx_last), 32'(k == NB - 1));
      tick();
    end
    chk("lsb_busy", 32'(b_busy), 32'd0);
    chk("lsb_count", 32'(b_count), 32'd1);

    // en dropped at data byte 5: frame completes, next block waits for en
    fill(128'hdeadbeef_01234567_89abcdef_fedcba98, 2'd2, 1'b1);
    send_block(128'hdeadbeef_01234567_89abcdef_fedcba98, 2'd2);
    recv_frame(NB, 1'b0, 6, -1);
    chk("t5_count", 32'(blk_count), 32'd3);
    blk_data  = 128'h00112233445566778899aabbccddeeff;
    blk_tag   = 2'd0;
    blk_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("en_low_ready", 32'(blk_ready), 32'd0);
      chk("en_low_busy", 32'(busy), 32'd0);
      tick();
    end
    en = 1'b1;
    #1;
    chk("en_high_ready", 32'(blk_ready), 32'd1);
    fill(128'h00112233445566778899aabbccddeeff, 2'd0, 1'b1);
    send_block(128'h00112233445566778899aabbccddeeff, 2'd0);
    recv_frame(NB, 1'b0, -1, -1);
    chk("t5b_count", 32'(blk_count), 32'd4);

    // Reset at data byte 8, then a fresh full frame
    fill(128'hcafef00d_55aa55aa_0f0f0f0f_12345678, 2'd1, 1'b1);
    send_block(128'hcafef00d_55aa55aa_0f0f0f0f_12345678, 2'd1);
    recv_frame(NB, 1'b0, -1, 9);
    chk("pre_rst_valid", 32'(tx_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(tx_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_count", 32'(blk_count), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    fill(128'h0badc0de_11223344_a5a5a5a5_77665544, 2'd3, 1'b1);
    send_block(128'h0badc0de_11223344_a5a5a5a5_77665544, 2'd3);
    recv_frame(NB, 1'b0, -1, -1);
    chk("t6_count", 32'(blk_count), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
